servo_pwm_gen: RTL and testbench
================================

// Module: servo_pwm_gen
// PURPOSE
// - Downstream of the key/switch angle-entry stage: takes four 8-bit servo angles (0..180 deg) and drives four 50 Hz servo PWM pins.
// - Angles are sampled only at frame boundaries, so a mid-frame change never produces a runt or stretched pulse.
// - Frame counter, per-channel threshold registers and an optional per-frame slew limiter.
// PARAMETERS
// - CLKS_PER_US  50     clocks per microsecond (50 MHz board clock)
// - FRAME_US     20000  PWM frame length, us (FRAME_CLKS = FRAME_US*CLKS_PER_US)
// - MIN_US       1000   pulse width at 0 deg, us
// - DEG_CLKS     278    extra clocks per degree (~1000 us / 180 deg at 50 MHz)
// - MAX_ANGLE    180    clamp ceiling for angle inputs
// - SLEW_STEP    2      max degrees the applied angle moves per frame (used only with SERVO_SLEW_EN)
// PORTS
// - clk          in   1  system clock, all logic on posedge
// - rst          in   1  synchronous reset, active-high
// - en           in   1  1 = generate frames; 0 = outputs low, counter held at 0
// - angle1..4    in   8  requested angle per channel, degrees, unsigned
// - pwm1..4      out  1  servo pulse outputs, registered
// - frame_start  out  1  one-clock pulse in the first cycle of each frame, registered
// - clamp_flag   out  1  registered; 1 for the frame if any angle sampled at its start exceeded MAX_ANGLE
// BEHAVIOUR
// - Clock: one clock, clk. Reset: synchronous, active-high, port rst.
// - Reset values: pwm1..4=0, frame_start=0, clamp_flag=0, counter=0, applied angles=90, thresholds=thr(90).
// - Counter cnt: 0..FRAME_CLKS-1, increments every clock while en=1, wraps to 0.
//   - Width: $clog2(FRAME_CLKS) bits, derived internally.
// - Frame boundary: a cycle where cnt==0 with en=1.
//   - At the boundary, per channel: a_i = min(angle_i, MAX_ANGLE); applied_i <= a_i; thr_i <= MIN_US*CLKS_PER_US + a_i*DEG_CLKS.
//   - Threshold arithmetic is at least 17 bits; no truncation.
// - Output timing:
//   - frame_start=1 in the output cycle corresponding to cnt==0.
//   - pwm_i=1 for exactly thr_i consecutive clocks, beginning in the same cycle as frame_start.
//   - pwm_i and frame_start come from the same register stage; 1-cycle latency from cnt.
// - Input changes: a change on angle_i mid-frame has no effect until the next boundary. The boundary sample is taken on the clock edge where cnt wraps to 0.
// - Clamping: angle_i > MAX_ANGLE is treated as MAX_ANGLE. clamp_flag is updated at each boundary.
// - Enable:
//   - en 1->0: the next edge forces pwm_i=0 and frame_start=0, cnt=0; applied angles and thresholds are held.
//   - en 0->1: the first enabled cycle is a boundary, so a fresh sample is taken.
// - Reset mid-frame: the next edge applies the reset values; the partial pulse is truncated.
//   - The first frame after rst falls starts on the first cycle with en=1.
// - Simultaneous rst and en: rst wins.
// - Invariant: thr_i < FRAME_CLKS for all legal parameters (max 100040 < 1000000), so pwm_i is never stuck high.
// CONFIGURATION
// - Macro SERVO_SLEW_EN.
// - Defined: at each boundary applied_i moves toward a_i by at most SLEW_STEP degrees:
//   - applied_i <= (|a_i - applied_i| <= SLEW_STEP) ? a_i : applied_i +/- SLEW_STEP
//   - thr_i is computed from the new applied_i. Signed compare, no underflow at 0 and no overshoot at MAX_ANGLE.
// - Undefined: applied_i = a_i at every boundary (step response); SLEW_STEP is ignored.
// TESTING
// - rst 4 cycles, en=1, angle1=0 -> frame_start every 1000000 clks; pwm1 high exactly 50000 clks per frame.
// - Angle width checks on pwm2/3/4: 90 -> 75020 clks; 180 -> 100040 clks; 200 -> 100040 clks and clamp_flag=1 that frame.
// - angle1 0->180 at cnt=10 -> current pulse stays 50000 clks; next frame 100040 clks. No glitch at the change.
// - rst pulsed at cnt=30000 with pwm1 high -> pwm1=0 on the next edge. After release, the first frame pwm widths are 75020 (90 deg) until the next boundary.
// - en low for 500 clks mid-frame, then high -> all pwm low while en=0; frame_start on the first cycle back; fresh angle sample.
// - SERVO_SLEW_EN, SLEW_STEP=2, applied=90, angle1=97 -> successive widths for 92,94,96,97 deg: 75576, 76132, 76688, 76966 clks.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: four-channel 50 Hz servo PWM; angles sampled at frame boundaries, optional slew limit via SERVO_SLEW_EN
module servo_pwm_gen #(
  parameter int CLKS_PER_US = 50,
  parameter int FRAME_US    = 20000,
  parameter int MIN_US      = 1000,
  parameter int DEG_CLKS    = 278,
  parameter int MAX_ANGLE   = 180,
  parameter int SLEW_STEP   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] angle1,
  input  logic [7:0] angle2,
  input  logic [7:0] angle3,
  input  logic [7:0] angle4,
  output logic       pwm1,
  output logic       pwm2,
  output logic       pwm3,
  output logic       pwm4,
  output logic       frame_start,
  output logic       clamp_flag
);
  localparam int FRAME_CLKS = FRAME_US * CLKS_PER_US;
  localparam int CW = $clog2(FRAME_CLKS);
  localparam int TW = CW > 17 ? CW : 17;
  function automatic logic [TW-1:0] thr_of(input logic [7:0] a);
    return TW'(MIN_US * CLKS_PER_US + int'(a) * DEG_CLKS);
  endfunction
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] ang [4];
  logic [7:0] a_c [4];
  logic [7:0] app_q [4];
  logic [7:0] app_d [4];
  logic [TW-1:0] thr_q [4];
  logic [TW-1:0] thr_d [4];
  logic [3:0] pwm_q, pwm_d, ovr;
  logic fs_q, fs_d, clamp_q, clamp_d, bnd;
`ifdef SERVO_SLEW_EN
  int diff [4];
`endif
  assign ang[0] = angle1;
  assign ang[1] = angle2;
  assign ang[2] = angle3;
  assign ang[3] = angle4;
  always_comb begin
    bnd = en && cnt_q == '0;
    cnt_d = (!en || cnt_q == CW'(FRAME_CLKS - 1)) ? '0 : cnt_q + CW'(1);
    fs_d = bnd;
    for (int i = 0; i < 4; i++) begin
      ovr[i] = ang[i] > 8'(MAX_ANGLE);
      a_c[i] = ovr[i] ? 8'(MAX_ANGLE) : ang[i];
`ifdef SERVO_SLEW_EN
      diff[i] = int'(a_c[i]) - int'(app_q[i]);
      app_d[i] = !bnd ? app_q[i] :
                 diff[i] > SLEW_STEP ? app_q[i] + 8'(SLEW_STEP) :
                 diff[i] < -SLEW_STEP ? app_q[i] - 8'(SLEW_STEP) : a_c[i];
`else
      app_d[i] = bnd ? a_c[i] : app_q[i];
`endif
      // the boundary cycle must already compare against the freshly sampled threshold
      thr_d[i] = bnd ? thr_of(app_d[i]) : thr_q[i];
      pwm_d[i] = en && TW'(cnt_q) < thr_d[i];
    end
    clamp_d = bnd ? |ovr : clamp_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= '0;
      fs_q <= 1'b0;
      clamp_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        app_q[i] <= 8'd90;
        thr_q[i] <= thr_of(8'd90);
      end
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      fs_q <= fs_d;
      clamp_q <= clamp_d;
      for (int i = 0; i < 4; i++) begin
        app_q[i] <= app_d[i];
        thr_q[i] <= thr_d[i];
      end
    end
  end
  assign {pwm4, pwm3, pwm2, pwm1} = pwm_q;
  assign frame_start = fs_q;
  assign clamp_flag = clamp_q;
endmodule

// File: tb/tb_servo_pwm_gen.sv
// tb_servo_pwm_gen: reference-model bench for servo_pwm_gen with scaled-down frame timing
module tb_servo_pwm_gen;
  localparam int CPU = 2, FUS = 300, MUS = 20, DC = 1, MA = 180, SS = 2;
  localparam int FR = FUS * CPU;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [7:0] ang [4];
  logic pwm1, pwm2, pwm3, pwm4, frame_start, clamp_flag;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int pos = 0, fs_seen = 0, per = 0, last_per = 0;
  int app [4];
  int w [4];
  int hi [4];
  int last [4];
  bit m_clamp = 0, m_fs = 0;
  bit [3:0] m_pwm = '0;
  servo_pwm_gen #(.CLKS_PER_US(CPU), .FRAME_US(FUS), .MIN_US(MUS), .DEG_CLKS(DC),
                  .MAX_ANGLE(MA), .SLEW_STEP(SS)) dut (
    .clk(clk), .rst(rst), .en(en),
    .angle1(ang[0]), .angle2(ang[1]), .angle3(ang[2]), .angle4(ang[3]),
    .pwm1(pwm1), .pwm2(pwm2), .pwm3(pwm3), .pwm4(pwm4),
    .frame_start(frame_start), .clamp_flag(clamp_flag));
  always #5 clk = ~clk;
  function automatic int thr(input int a);
    return MUS * CPU + a * DC;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  task automatic step();
    int a;
    @(posedge clk);
    if (rst) begin
      pos = 0; m_clamp = 0; m_pwm = '0; m_fs = 0;
      for (int i = 0; i < 4; i++) begin app[i] = 90; w[i] = thr(90); end
    end else if (!en) begin
      pos = 0; m_pwm = '0; m_fs = 0;
    end else begin
      if (pos == 0) begin
        m_clamp = 0;
        for (int i = 0; i < 4; i++) begin
          if (int'(ang[i]) > MA) m_clamp = 1;
          a = int'(ang[i]) > MA ? MA : int'(ang[i]);
`ifdef SERVO_SLEW_EN
          app[i] = (a - app[i] > SS) ? app[i] + SS : (app[i] - a > SS) ? app[i] - SS : a;
`else
          app[i] = a;
`endif
          w[i] = thr(app[i]);
        end
      end
      m_fs = pos == 0;
      for (int i = 0; i < 4; i++) m_pwm[i] = pos < w[i];
      pos = (pos + 1) % FR;
    end
    #1;
    cyc++;
    chk("pwm", {28'd0, pwm4, pwm3, pwm2, pwm1}, {28'd0, m_pwm});
    chk("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
    chk("clamp_flag", {31'd0, clamp_flag}, {31'd0, m_clamp});
    if (frame_start) begin
      last = hi; last_per = per; per = 0; fs_seen++;
      for (int i = 0; i < 4; i++) hi[i] = 0;
    end
    per++;
    hi[0] += int'(pwm1); hi[1] += int'(pwm2); hi[2] += int'(pwm3); hi[3] += int'(pwm4);
  endtask
  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask
  task automatic wait_fs(input int n);
    int s0, budget;
    s0 = fs_seen;
    budget = n * FR + FR;
    while (fs_seen < s0 + n && budget > 0) begin step(); budget--; end
    chk("frame_start wait", fs_seen - s0, n);
  endtask
  initial begin
    int pick [7];
    pick = '{0, 1, 90, 179, 180, 181, 255};
    for (int i = 0; i < 4; i++) begin hi[i] = 0; last[i] = 0; ang[i] = 8'd90; end
    steps(4);
`ifdef SERVO_SLEW_EN
    ang[0] = 8'd97;
    rst = 1'b0; en = 1'b1;
    wait_fs(2); chk("slew width 92", last[0], 132);
    wait_fs(1); chk("slew width 94", last[0], 134);
    wait_fs(1); chk("slew width 96", last[0], 136);
    wait_fs(1); chk("slew width 97", last[0], 137);
    rst = 1'b1; steps(2); rst = 1'b0;
`endif
    ang[0] = 8'd0; ang[1] = 8'd90; ang[2] = 8'd180; ang[3] = 8'd200;
    rst = 1'b0; en = 1'b1;
    step();
    chk("first frame_start", {31'd0, frame_start}, 32'd1);
    wait_fs(2);
    chk("frame period", last_per, FR);
    chk("clamp literal", {31'd0, clamp_flag}, 32'd1);
`ifndef SERVO_SLEW_EN
    chk("width 0deg", last[0], 40);
    chk("width 90deg", last[1], 130);
    chk("width 180deg", last[2], 220);
    chk("width 200deg", last[3], 220);
    steps(10);
    ang[0] = 8'd180;
    wait_fs(1); chk("width unchanged mid-frame", last[0], 40);
    wait_fs(1); chk("width after change", last[0], 220);
`endif
    steps(20);
    chk("pwm1 high before rst", {31'd0, pwm1}, 32'd1);
    for (int i = 0; i < 4; i++) ang[i] = 8'd90;
    rst = 1'b1; step();
    chk("pwm1 cut by rst", {31'd0, pwm1}, 32'd0);
    rst = 1'b0;
    wait_fs(2);
    for (int i = 0; i < 4; i++) chk("width after rst", last[i], 130);
    chk("clamp cleared", {31'd0, clamp_flag}, 32'd0);
    steps(100);
    en = 1'b0; ang[1] = 8'd10;
    steps(150);
    chk("pwm low while disabled", {28'd0, pwm4, pwm3, pwm2, pwm1}, 32'd0);
    en = 1'b1; step();
    chk("frame_start on re-enable", {31'd0, frame_start}, 32'd1);
    wait_fs(1);
`ifndef SERVO_SLEW_EN
    chk("fresh sample after re-enable", last[1], 50);
`endif
    for (int k = 0; k < 15000; k++) begin
      if ($urandom_range(0, 49) == 0)
        ang[$urandom_range(0, 3)] = $urandom_range(0, 1) ? 8'(pick[$urandom_range(0, 6)]) : 8'($urandom_range(0, 255));
      if (en) en = $urandom_range(0, 999) != 0;
      else en = $urandom_range(0, 49) == 0;
      rst = $urandom_range(0, 2999) == 0;
      step();
    end
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
